display_ctrl_param: RTL and testbench
=====================================

Name: display_ctrl_param

Overview:
Parametrised memory-mapped raster display controller, successor to display_module. Owns a dual-port framebuffer written and read back by the CPU bus, a programmable-timing sync generator, pixel replication (SCALE), a control/status register pair and a vblank interrupt. Sits between the core's data-memory bus and the board VGA pins.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync width (lines)
V_BP, 33, vertical back porch (lines)
PIX_DIV, 2, clk cycles per pixel; must be >=1
COLOR_W, 8, bits per pixel; must be <=32
SCALE, 1, replication factor (1, 2 or 4); framebuffer is (H_ACTIVE/SCALE) x (V_ACTIVE/SCALE)
BASE_ADDR, 32'h1000_0000, framebuffer base byte address
CTRL_OFF, 32'h0008_0000, register block offset from BASE_ADDR
SYNC_POL, 0, 0 = active-low syncs, 1 = active-high

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
data  in  32  bus write data
waddr  in  32  bus byte address (read and write)
w_en  in  1  write strobe
r_en  in  1  read strobe
rdata  out  32  read data, 1-cycle latency
irq  out  1  vblank interrupt, level
rgb  out  COLOR_W  pixel colour
hsync  out  1  horizontal sync
vsync  out  1  vertical sync
de  out  1  display-enable (active area)
x_out  out  10  horizontal counter of displayed pixel
y_out  out  10  vertical counter of displayed pixel
ptk  out  1  one-clk pulse per pixel, aligned with output update

Behaviour:
- Reset (rst=0, async): all counters 0, rgb=0, hsync/vsync inactive level, de=0, x_out=y_out=0, ptk=0, rdata=0, irq=0, CTRL=32'h1, STATUS cleared. Framebuffer contents undefined.
- Pixel tick: divider counts 0..PIX_DIV-1; tick when divider wraps. h counter advances on tick, wraps at H_ACTIVE+H_FP+H_SYNC+H_BP-1 to 0 and advances v; v wraps at V total-1.
- Active area: h<H_ACTIVE && v<V_ACTIVE. Sync asserted for h in [H_ACTIVE+H_FP, +H_SYNC), v likewise; polarity per SYNC_POL.
- Pipeline: fixed 2-clk latency counter->outputs; rgb, hsync, vsync, de, x_out, y_out, ptk all delayed equally so every output on a given cycle describes the same pixel. Outputs hold between ticks.
- rgb = framebuffer[(v/SCALE)*(H_ACTIVE/SCALE) + h/SCALE] when de && CTRL.enable; else 0.
- Bus decode: off = waddr-BASE_ADDR. off < FB size -> framebuffer, pixel index = off, stores data[COLOR_W-1:0]. off==CTRL_OFF -> CTRL; off==CTRL_OFF+4 -> STATUS. Anything else: writes ignored, reads return 0.
- CTRL: bit0 display enable, bit1 irq enable; other bits read 0.
- STATUS: bit0 in_vblank (v>=V_ACTIVE), bit1 irq pending (write 1 clears), [31:16] frame counter (increments at v wrap, wraps at 16'hFFFF->0).
- irq pending set on tick where v transitions V_ACTIVE-1 -> V_ACTIVE; irq = pending && CTRL.bit1. Set and clear in same cycle: set wins.
- Read: r_en with decoded address -> rdata valid next cycle, zero-extended. w_en and r_en same cycle same address: rdata returns old value.
- Display read port independent of bus port; bus write to the pixel being scanned shows new value no later than next frame.

Test Plan:
- Defaults, no writes: hsync low 96 px = 192 clk per line, line = 1600 clk, vsync low 2 lines every 525 lines, de high 640 px/line.
- Write 0xFF @ 32'h1000_0281 -> rgb=0xFF exactly when x_out=1,y_out=1, 0 at (0,1),(2,1); write @ 32'h0000_0001 -> no pixel changes, read back 0.
- SCALE=2: write 0xAA @ BASE_ADDR+1 -> rgb=0xAA at (2,0),(3,0),(2,1),(3,1) only.
- CTRL=32'h3, run to line 480 -> irq=1, STATUS bit1=1; write STATUS=2 -> irq=0; frame counter reads 1 after first wrap.
- CTRL=0 -> rgb stays 0 with syncs unchanged; read CTRL returns 0.
- Assert rst mid-line (x=300,y=100) -> outputs return to reset values asynchronously; after release counting restarts from (0,0); framebuffer readback preserved.

Source files
------------

// File: rtl/display_ctrl_param.sv
// Memory-mapped raster display controller: dual-port framebuffer, programmable
// sync timing with pixel replication, CTRL/STATUS registers and a vblank irq.
module display_ctrl_param #(
    parameter int unsigned H_ACTIVE  = 640,
    parameter int unsigned H_FP      = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BP      = 48,
    parameter int unsigned V_ACTIVE  = 480,
    parameter int unsigned V_FP      = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BP      = 33,
    parameter int unsigned PIX_DIV   = 2,
    parameter int unsigned COLOR_W   = 8,
    parameter int unsigned SCALE     = 1,
    parameter logic [31:0] BASE_ADDR = 32'h1000_0000,
    parameter logic [31:0] CTRL_OFF  = 32'h0008_0000,
    parameter bit          SYNC_POL  = 1'b0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [31:0]        data,
    input  logic [31:0]        waddr,
    input  logic               w_en,
    input  logic               r_en,
    output logic [31:0]        rdata,
    output logic               irq,
    output logic [COLOR_W-1:0] rgb,
    output logic               hsync,
    output logic               vsync,
    output logic               de,
    output logic [9:0]         x_out,
    output logic [9:0]         y_out,
    output logic               ptk
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned H_W     = $clog2(H_TOTAL);
    localparam int unsigned V_W     = $clog2(V_TOTAL);
    localparam int unsigned DIV_W   = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
    localparam int unsigned FB_W    = H_ACTIVE / SCALE;
    localparam int unsigned FB_H    = V_ACTIVE / SCALE;
    localparam int unsigned FB_SIZE = FB_W * FB_H;
    localparam int unsigned FB_AW   = (FB_SIZE > 1) ? $clog2(FB_SIZE) : 1;

    logic [DIV_W-1:0]   div_cnt;
    logic [H_W-1:0]     h_cnt;
    logic [V_W-1:0]     v_cnt;
    logic [15:0]        frame_cnt;
    logic               new_pix;
    logic [31:0]        h_ext_c;
    logic [31:0]        v_ext_c;
    logic               tick_c;
    logic               h_wrap_c;
    logic               v_wrap_c;
    logic               vb_set_c;
    logic               active_c;
    logic               hs_on_c;
    logic               vs_on_c;
    logic [FB_AW-1:0]   pix_addr_c;

    logic [COLOR_W-1:0] fb [FB_SIZE];
    logic [COLOR_W-1:0] pix_q;

    logic               s1_de;
    logic               s1_hs;
    logic               s1_vs;
    logic               s1_ptk;
    logic [9:0]         s1_x;
    logic [9:0]         s1_y;

    logic [1:0]         ctrl;
    logic               pending;
    logic [31:0]        off_c;
    logic               fb_hit_c;
    logic               ctrl_hit_c;
    logic               stat_hit_c;
    logic [FB_AW-1:0]   bus_idx_c;
    logic [31:0]        status_c;
    logic [31:0]        rd_val_c;
    logic [1:0]         ctrl_nxt_c;
    logic               pend_nxt_c;
    logic               unused_data_c;

    assign h_ext_c  = 32'(h_cnt);
    assign v_ext_c  = 32'(v_cnt);
    assign tick_c   = (32'(div_cnt) == PIX_DIV - 1);
    assign h_wrap_c = (h_ext_c == H_TOTAL - 1);
    assign v_wrap_c = (v_ext_c == V_TOTAL - 1);
    assign vb_set_c = tick_c && h_wrap_c && (v_ext_c == V_ACTIVE - 1);
    assign active_c = (h_ext_c < H_ACTIVE) && (v_ext_c < V_ACTIVE);
    assign hs_on_c  = (h_ext_c >= H_ACTIVE + H_FP) && (h_ext_c < H_ACTIVE + H_FP + H_SYNC);
    assign vs_on_c  = (v_ext_c >= V_ACTIVE + V_FP) && (v_ext_c < V_ACTIVE + V_FP + V_SYNC);
    assign pix_addr_c = active_c ?
        FB_AW'((v_ext_c / SCALE) * FB_W + h_ext_c / SCALE) : '0;

    // Pixel divider, raster counters and frame counter
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div_cnt   <= '0;
            h_cnt     <= '0;
            v_cnt     <= '0;
            frame_cnt <= '0;
            new_pix   <= 1'b0;
        end else begin
            new_pix <= tick_c;
            if (tick_c) begin
                div_cnt <= '0;
                if (h_wrap_c) begin
                    h_cnt <= '0;
                    if (v_wrap_c) begin
                        v_cnt     <= '0;
                        frame_cnt <= frame_cnt + 1'b1;
                    end else begin
                        v_cnt <= v_cnt + 1'b1;
                    end
                end else begin
                    h_cnt <= h_cnt + 1'b1;
                end
            end else begin
                div_cnt <= div_cnt + 1'b1;
            end
        end
    end

    // Framebuffer: bus write port plus independent display read port
    always_ff @(posedge clk) begin
        if (w_en && fb_hit_c) begin
            fb[bus_idx_c] <= data[COLOR_W-1:0];
        end
        pix_q <= fb[pix_addr_c];
    end

    // Stage 1 aligns timing flags with the synchronous framebuffer read
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1_de  <= 1'b0;
            s1_hs  <= !SYNC_POL;
            s1_vs  <= !SYNC_POL;
            s1_ptk <= 1'b0;
            s1_x   <= '0;
            s1_y   <= '0;
        end else begin
            s1_de  <= active_c;
            s1_hs  <= (hs_on_c == SYNC_POL);
            s1_vs  <= (vs_on_c == SYNC_POL);
            s1_ptk <= new_pix;
            s1_x   <= 10'(h_cnt);
            s1_y   <= 10'(v_cnt);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rgb   <= '0;
            hsync <= !SYNC_POL;
            vsync <= !SYNC_POL;
            de    <= 1'b0;
            ptk   <= 1'b0;
            x_out <= '0;
            y_out <= '0;
        end else begin
            rgb   <= (s1_de && ctrl[0]) ? pix_q : '0;
            hsync <= s1_hs;
            vsync <= s1_vs;
            de    <= s1_de;
            ptk   <= s1_ptk;
            x_out <= s1_x;
            y_out <= s1_y;
        end
    end

    assign off_c      = waddr - BASE_ADDR;
    assign fb_hit_c   = (off_c < FB_SIZE);
    assign ctrl_hit_c = (off_c == CTRL_OFF);
    assign stat_hit_c = (off_c == CTRL_OFF + 32'd4);
    assign bus_idx_c  = off_c[FB_AW-1:0];
    assign status_c   = {frame_cnt, 14'd0, pending, (v_ext_c >= V_ACTIVE)};
    assign unused_data_c = ^data;

    // Register next-state; a vblank set outranks a same-cycle clear
    always_comb begin
        ctrl_nxt_c = ctrl;
        pend_nxt_c = pending;
        rd_val_c   = '0;
        if (w_en && ctrl_hit_c) begin
            ctrl_nxt_c = data[1:0];
        end
        if (w_en && stat_hit_c && data[1]) begin
            pend_nxt_c = 1'b0;
        end
        if (vb_set_c) begin
            pend_nxt_c = 1'b1;
        end
        if (fb_hit_c) begin
            rd_val_c = 32'(fb[bus_idx_c]);
        end else if (ctrl_hit_c) begin
            rd_val_c = {30'd0, ctrl};
        end else if (stat_hit_c) begin
            rd_val_c = status_c;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ctrl    <= 2'b01;
            pending <= 1'b0;
            irq     <= 1'b0;
            rdata   <= '0;
        end else begin
            ctrl    <= ctrl_nxt_c;
            pending <= pend_nxt_c;
            irq     <= pend_nxt_c && ctrl_nxt_c[1];
            if (r_en) begin
                rdata <= rd_val_c;
            end
        end
    end

endmodule

// File: tb/tb_display_ctrl_param.sv
// Randomized bench for display_ctrl_param: every output is predicted from the
// cycle count since reset and a shadow copy of the framebuffer and registers.
module tb_display_ctrl_param;

    localparam int unsigned HA = 16, HFP = 2, HS = 3, HBP = 2;
    localparam int unsigned VA = 8,  VFP = 1, VS = 2, VBP = 1;
    localparam int unsigned PD = 2, CW = 8, SC = 2;
    localparam int unsigned HT = HA + HFP + HS + HBP;
    localparam int unsigned VT = VA + VFP + VS + VBP;
    localparam int unsigned FRAME = HT * VT * PD;
    localparam int unsigned FBW = HA / SC;
    localparam int unsigned FBN = FBW * (VA / SC);
    localparam logic [31:0] BASE = 32'h1000_0000;
    localparam logic [31:0] COFF = 32'h0008_0000;

    logic          clk = 1'b0;
    logic          rst;
    logic [31:0]   data;
    logic [31:0]   waddr;
    logic          w_en;
    logic          r_en;
    logic [31:0]   rdata;
    logic          irq;
    logic [CW-1:0] rgb;
    logic          hsync;
    logic          vsync;
    logic          de;
    logic [9:0]    x_out;
    logic [9:0]    y_out;
    logic          ptk;

    logic [7:0]    fb_m [FBN];
    logic [1:0]    ctrl_m;
    int unsigned   cyc;
    int unsigned   clr_base;
    int            n_checks = 0;
    int            n_fail = 0;

    display_ctrl_param #(
        .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
        .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
        .PIX_DIV(PD), .COLOR_W(CW), .SCALE(SC),
        .BASE_ADDR(BASE), .CTRL_OFF(COFF), .SYNC_POL(1'b0)
    ) u_dut (
        .clk(clk), .rst(rst), .data(data), .waddr(waddr), .w_en(w_en), .r_en(r_en),
        .rdata(rdata), .irq(irq), .rgb(rgb), .hsync(hsync), .vsync(vsync), .de(de),
        .x_out(x_out), .y_out(y_out), .ptk(ptk)
    );

    always #5 clk = ~clk;

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Number of vblank entries that have happened after k clock edges
    function automatic int unsigned vb_entries(input int unsigned k);
        int unsigned p;
        p = k / PD;
        return (p >= VA * HT) ? (p - VA * HT) / (HT * VT) + 1 : 0;
    endfunction

    function automatic logic pend_m(input int unsigned k);
        return vb_entries(k) > clr_base;
    endfunction

    function automatic logic [31:0] status_m(input int unsigned k);
        int unsigned p;
        int unsigned v;
        p = k / PD;
        v = (p / HT) % VT;
        return {16'((p / (HT * VT)) % 65536), 14'd0, pend_m(k), v >= VA};
    endfunction

    function automatic logic [63:0] disp_m(input int unsigned k);
        int unsigned j, p, h, v;
        logic d, hs, vs, pk, ie;
        logic [7:0] px;
        ie = pend_m(k) && ctrl_m[1];
        if (k < 2) return {31'd0, ie, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'd0};
        j = k - 2;
        p = j / PD;
        h = p % HT;
        v = (p / HT) % VT;
        d = (h < HA) && (v < VA);
        hs = !((h >= HA + HFP) && (h < HA + HFP + HS));
        vs = !((v >= VA + VFP) && (v < VA + VFP + VS));
        pk = (j >= 1) && (j % PD == 0);
        px = (d && ctrl_m[0]) ? fb_m[(v / SC) * FBW + h / SC] : 8'h00;
        return {31'd0, ie, pk, d, hs, vs, 10'(h), 10'(v), px};
    endfunction

    function automatic logic [63:0] disp_obs();
        return {31'd0, irq, ptk, de, hsync, vsync, x_out, y_out, rgb};
    endfunction

    function automatic logic [31:0] junk_addr(input int unsigned s);
        case (s % 5)
            0:       return 32'h0000_0001;
            1:       return BASE + 32'(FBN);
            2:       return BASE + COFF + 32'd8;
            3:       return BASE - 32'd1;
            default: return BASE + COFF - 32'd4;
        endcase
    endfunction

    task automatic step(input bit chk);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        if (chk) check("disp", disp_obs(), disp_m(cyc));
    endtask

    task automatic bus_wr(input logic [31:0] a, input logic [31:0] d);
        logic [31:0] off;
        waddr = a;
        data = d;
        w_en = 1'b1;
        step(1'b0);
        w_en = 1'b0;
        off = a - BASE;
        if (off < FBN) fb_m[off] = d[7:0];
        else if (off == COFF) ctrl_m = d[1:0];
        else if (off == COFF + 32'd4 && d[1]) clr_base = vb_entries(cyc - 1);
    endtask

    task automatic bus_rd(input string tag, input logic [31:0] a);
        logic [31:0] off;
        logic [31:0] exp;
        off = a - BASE;
        if (off < FBN) exp = 32'(fb_m[off]);
        else if (off == COFF) exp = {30'd0, ctrl_m};
        else if (off == COFF + 32'd4) exp = status_m(cyc);
        else exp = 32'd0;
        waddr = a;
        r_en = 1'b1;
        step(1'b0);
        r_en = 1'b0;
        check(tag, 64'(rdata), 64'(exp));
    endtask

    task automatic scan(input int unsigned n);
        repeat (2) step(1'b0);
        repeat (n) step(1'b1);
    endtask

    task automatic do_reset();
        rst = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        ctrl_m = 2'b01;
        clr_base = 0;
    endtask

    initial begin
        int unsigned hs_lo, vs_lo, de_hi, pk_n, aa_n, nz_n;
        logic [31:0] d;
        rst = 1'b0;
        data = '0;
        waddr = '0;
        w_en = 1'b0;
        r_en = 1'b0;
        cyc = 0;
        ctrl_m = 2'b01;
        clr_base = 0;
        #12;
        check("reset_outputs", disp_obs(), {31'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'd0});
        check("reset_rdata", 64'(rdata), 64'd0);
        do_reset();

        bus_rd("ctrl_reset", BASE + COFF);
        bus_rd("status_reset", BASE + COFF + 32'd4);
        for (int i = 0; i < FBN; i++) bus_wr(BASE + 32'(i), 32'd0);

        // Sync/de/tick totals over one whole frame
        repeat (2) step(1'b0);
        hs_lo = 0; vs_lo = 0; de_hi = 0; pk_n = 0;
        repeat (FRAME) begin
            step(1'b1);
            hs_lo += 32'(!hsync);
            vs_lo += 32'(!vsync);
            de_hi += 32'(de);
            pk_n  += 32'(ptk);
        end
        check("hsync_low_cycles", 64'(hs_lo), 64'(HS * PD * VT));
        check("vsync_low_cycles", 64'(vs_lo), 64'(VS * HT * PD));
        check("de_high_cycles", 64'(de_hi), 64'(HA * VA * PD));
        check("ptk_pulses", 64'(pk_n), 64'(HT * VT));

        // One stored pixel replicated to a 2x2 block
        bus_wr(BASE + 32'd1, 32'h0000_00AA);
        repeat (2) step(1'b0);
        aa_n = 0;
        repeat (FRAME) begin
            step(1'b1);
            if (rgb == 8'hAA) begin
                aa_n++;
                check("aa_xy", 64'((x_out inside {10'd2, 10'd3}) && (y_out inside {10'd0, 10'd1})), 64'd1);
            end
        end
        check("aa_cycles", 64'(aa_n), 64'(4 * PD));

        bus_wr(32'h0000_0001, 32'h0000_0055);
        bus_rd("oob_read", 32'h0000_0001);
        bus_rd("fb_after_oob", BASE + 32'd1);
        scan(FRAME);

        // vblank interrupt
        bus_wr(BASE + COFF, 32'h3);
        bus_wr(BASE + COFF + 32'd4, 32'h2);
        step(1'b1);
        for (int i = 0; i < 2 * FRAME && ((cyc / PD) / HT) % VT != VA; i++) step(1'b1);
        check("reach_vblank", 64'(((cyc / PD) / HT) % VT), 64'(VA));
        check("irq_set", 64'(irq), 64'd1);
        bus_rd("status_vblank", BASE + COFF + 32'd4);
        check("status_pending", 64'(rdata[1:0]), 64'd3);
        bus_wr(BASE + COFF + 32'd4, 32'h2);
        check("irq_clear", 64'(irq), 64'd0);
        bus_rd("status_cleared", BASE + COFF + 32'd4);

        // Display disabled: syncs keep running, pixels blank
        bus_wr(BASE + COFF, 32'h0);
        bus_rd("ctrl_zero", BASE + COFF);
        repeat (2) step(1'b0);
        nz_n = 0;
        repeat (FRAME) begin
            step(1'b1);
            nz_n += 32'(rgb != 8'h00);
        end
        check("rgb_blank", 64'(nz_n), 64'd0);

        // Random bus traffic followed by a checked frame
        for (int r = 0; r < 5; r++) begin
            for (int i = 0; i < 14; i++) begin
                d = $urandom;
                case ($urandom_range(0, 5))
                    0, 1: bus_wr(BASE + 32'($urandom_range(0, FBN - 1)), d);
                    2: begin
                        if ($urandom_range(0, 3) != 0) d[0] = 1'b1;
                        bus_wr(BASE + COFF, d);
                    end
                    3: bus_wr(BASE + COFF + 32'd4, d);
                    4: bus_wr(junk_addr($urandom), d);
                    default: begin
                        case ($urandom_range(0, 3))
                            0: bus_rd("rand_rd_fb", BASE + 32'($urandom_range(0, FBN - 1)));
                            1: bus_rd("rand_rd_ctrl", BASE + COFF);
                            2: bus_rd("rand_rd_status", BASE + COFF + 32'd4);
                            default: bus_rd("rand_rd_junk", junk_addr($urandom));
                        endcase
                    end
                endcase
            end
            if (r == 4) bus_wr(BASE + COFF, 32'h3);
            scan(FRAME);
        end

        // Asynchronous reset mid-line, then restart from (0,0)
        for (int i = 0; i < 2 * FRAME && !(((cyc / PD) % HT == 10) && (((cyc / PD) / HT) % VT == 3)); i++)
            step(1'b1);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", disp_obs(), {31'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0, 8'd0});
        check("async_reset_rdata", 64'(rdata), 64'd0);
        @(negedge clk);
        rst = 1'b1;
        cyc = 0;
        ctrl_m = 2'b01;
        clr_base = 0;
        step(1'b1);
        step(1'b1);
        check("restart_xy", 64'({x_out, y_out}), 64'd0);
        bus_rd("ctrl_after_reset", BASE + COFF);
        for (int i = 0; i < FBN; i++) bus_rd("fb_preserved", BASE + 32'(i));
        scan(FRAME);
        for (int i = 0; i < 2 * FRAME && cyc / PD < HT * VT; i++) step(1'b1);
        bus_rd("status_frame1", BASE + COFF + 32'd4);
        check("frame_count", 64'(rdata[31:16]), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
